// File: rtl/button_pkg.sv
// Shared definitions for the button event block: FSM state encoding and
// elaboration-time helpers used to size the hold/repeat counter.
package button_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_LONG    = 2'd2;

    // Encoding 2'd3 is unused and steers back to IDLE in the FSM.
    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        PRESSED = S_PRESSED,
        LONG    = S_LONG
    } state_t;

    // Smallest width w such that 2**w >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Counter width covering both terminal counts, never narrower than 1 bit.
    function automatic int counter_width(input int long_cyc, input int rep_cyc);
        int span;
        int width;
        span  = (long_cyc > rep_cyc) ? long_cyc : rep_cyc;
        width = clog2(span);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the asynchronous button level, followed by a
// previous-value flop so single-cycle rise/fall strobes can be derived.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain plus delayed copy for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments make every flop sample the old value of
        // its neighbour, which is what turns these three lines into a shift chain.
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press / release / long_press / repeat
// pulses plus a held level. Timing is counted in clock cycles derived from
// CLK_HZ so the millisecond parameters stay human-readable.
module button_event
    import button_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic db_in,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;
    localparam int CNT_W    = counter_width(LONG_CYC, REP_CYC);
    localparam bit REP_ON   = (REP_CYC != 0);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_ON ? REP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic level_unused;
    logic rise;
    logic fall;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;
    logic             release_next;
    logic             long_next;
    logic             repeat_next;
    logic             held_next;

    sync_edge u_sync_edge (
        .clock (clock),
        .reset (reset),
        .d     (db_in),
        .level (level_unused),
        .rise  (rise),
        .fall  (fall)
    );

    // Next-state, counter and pulse decode; fall always wins over a terminal count.
    always_comb begin
        // NOTE: every output of this block gets a default up front so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG;
                    cnt_next   = '0;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            LONG: begin
                if (fall) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else if (REP_ON && (cnt == REP_LAST)) begin
                    cnt_next    = '0;
                    repeat_next = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        held_next = (state_next != IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            press         <= press_next;
            release_pulse <= release_next;
            long_press    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= held_next;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event at 1 cycle = 1 ms. Two instances share db_in/reset:
// one with auto-repeat every 4 ms, one with repeat disabled. Expected pulses
// come from a model that reasons about the sampled db_in history: the
// synchronized level lags db_in by two edges, and long/repeat pulses fall at
// fixed ages measured from the press edge.
module tb_button_event;

    localparam int CLK_HZ    = 1000;
    localparam int LONG_MS   = 10;
    localparam int REPEAT_MS = 4;
    localparam int LONG_CYC  = CLK_HZ / 1000 * LONG_MS;
    localparam int REP_CYC   = CLK_HZ / 1000 * REPEAT_MS;
    localparam int HIST      = 16384;

    logic clock = 1'b0;
    logic reset;
    logic db_in;

    logic a_press, a_release, a_long, a_repeat, a_held;
    logic b_press, b_release, b_long, b_repeat, b_held;

    int   vectors     = 0;
    int   miscompares = 0;
    int   e           = 0;        // edges since the last reset release
    int   p           = -100000;  // edge index of the most recent press
    logic h [HIST];               // db_in value sampled at each edge

    button_event #(
        .CLK_HZ    (CLK_HZ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut_a (
        .clock         (clock),
        .reset         (reset),
        .db_in         (db_in),
        .press         (a_press),
        .release_pulse (a_release),
        .long_press    (a_long),
        .repeat_pulse  (a_repeat),
        .held          (a_held)
    );

    button_event #(
        .CLK_HZ    (CLK_HZ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (0)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .db_in         (db_in),
        .press         (b_press),
        .release_pulse (b_release),
        .long_press    (b_long),
        .repeat_pulse  (b_repeat),
        .held          (b_held)
    );

    initial forever #5 clock = ~clock;

    function automatic logic hv(input int i);
        return (i < 1) ? 1'b0 : h[i];
    endfunction

    // Expected {press, release, long_press, repeat, held} after edge e.
    function automatic logic [4:0] model(input int rep_cyc, input logic pr);
        logic lvl;
        logic rel;
        logic lp;
        logic rp;
        int   age;
        lvl = hv(e - 2);
        age = e - p;
        rel = !lvl && hv(e - 3);
        lp  = lvl && !pr && (age == LONG_CYC);
        rp  = lvl && !pr && (rep_cyc > 0) && (age > LONG_CYC)
              && (((age - LONG_CYC) % ((rep_cyc > 0) ? rep_cyc : 1)) == 0);
        return {pr, rel, lp, rp, lvl};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {a_press, a_release, a_long, a_repeat, a_held}, 5'b0);
        check({tag, "_b"}, {b_press, b_release, b_long, b_repeat, b_held}, 5'b0);
    endtask

    // Drive one db_in value for one clock and compare both instances after the edge.
    task automatic step(input logic v);
        logic pr;
        db_in = v;
        @(posedge clock);
        e++;
        h[e] = v;
        #1;
        pr = hv(e - 2) & ~hv(e - 3);
        if (pr) p = e;
        check("dut_a", {a_press, a_release, a_long, a_repeat, a_held}, model(REP_CYC, pr));
        check("dut_b", {b_press, b_release, b_long, b_repeat, b_held}, model(0, pr));
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Assert reset part-way through a cycle, confirm outputs clear at once,
    // then release it mid-cycle so the next edge is edge 1 of a new timeline.
    task automatic do_reset(input int phase);
        #(phase);
        reset = 1'b1;
        #1;
        check_zero("reset_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            check_zero("reset_held");
        end
        #(phase);
        reset = 1'b0;
        e = 0;
        p = -100000;
    endtask

    initial begin
        reset = 1'b1;
        db_in = 1'b0;
        #1;
        check_zero("power_on");
        @(posedge clock);
        #1;
        check_zero("power_on_edge");
        #3;
        reset = 1'b0;

        hold(1'b0, 4);

        // Short press: 5 cycles high.
        hold(1'b1, 5);
        hold(1'b0, 8);

        // Long hold with repeats: 25 cycles high.
        hold(1'b1, 25);
        hold(1'b0, 8);

        // Fall detected exactly where the long count would terminate, then one cycle later.
        hold(1'b1, LONG_CYC);
        hold(1'b0, 8);
        hold(1'b1, LONG_CYC + 1);
        hold(1'b0, 6);

        // 40-cycle hold: dut_b must show one long_press and never a repeat.
        hold(1'b1, 40);
        hold(1'b0, 8);

        // Reset six cycles after press, db_in staying high throughout.
        hold(1'b1, 3);
        hold(1'b1, 6);
        do_reset($urandom_range(1, 7));
        hold(1'b1, 15);
        hold(1'b0, 8);

        // Single-cycle high pulse.
        hold(1'b1, 1);
        hold(1'b0, 6);

        // Reset released with db_in already high.
        db_in = 1'b1;
        do_reset($urandom_range(1, 7));
        hold(1'b1, 6);
        hold(1'b0, 5);

        // Random hold / gap lengths, occasionally resetting mid-hold.
        for (int k = 0; k < 40; k++) begin
            hold(1'b1, $urandom_range(1, 30));
            if ($urandom_range(0, 7) == 0) begin
                do_reset($urandom_range(1, 7));
                hold(1'b1, $urandom_range(1, 20));
            end
            hold(1'b0, $urandom_range(1, 8));
        end
        hold(1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
